mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequential arbiter that shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined CPU.
- Produces the ihit/dhit pulses consumed by the hazard unit for pipeline enables and flushes.
- Data port has priority; a starvation limit guarantees forward progress for fetch.
- A timeout and RAM-error path prevent the pipeline from hanging.

Parameters:
MAX_DSTREAK, 4, consecutive contested data grants allowed before fetch is forced to win (must be >= 1)
TIMEOUT, 64, max cycles in a grant state without ACCESS/ERROR before abort; 0 disables the timeout

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  32  instruction address (word_t)
iload  output  32  instruction read data
ihit  output  1  instruction access complete (one-cycle pulse)
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  32  data address
dstore  input  32  data write data
dload  output  32  data read data
dhit  output  1  data access complete (one-cycle pulse)
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
busy  output  1  state != IDLE
mem_err  output  1  pulse: RAM ERROR or timeout abort

Behaviour:
- Clocking and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset state: IDLE, dstreak=0, tcount=0.
- Reset values of outputs: all outputs 0, including ram strobes, which drop immediately when nRST asserts, even mid-transaction.
- FSM states: IDLE, GNT_I, GNT_D, TURN.
- IDLE arbitration, registered into the next state:
  - dreq=dREN|dWEN. If dreq and iREN and dstreak==MAX_DSTREAK -> GNT_I.
  - Otherwise, if dreq -> GNT_D; else if iREN -> GNT_I; else stay IDLE.
- dstreak update at each arbitration:
  - +1 (saturating) on a GNT_D grant while iREN is high.
  - Cleared on a GNT_I grant, or on a GNT_D grant while iREN is low.
- Grant states drive the RAM combinationally from the owner's inputs:
  - GNT_I: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - GNT_D: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are asserted).
  - IDLE and TURN: all ram outputs 0.
- Completion happens in a grant state with ramstate==ACCESS and the owner request still high:
  - Owner hit=1 in that same cycle (combinational).
  - Owner load=ramload in that cycle (reads only; writes give dload=0).
  - Next state is TURN.
  - Loads are 0 whenever the corresponding hit is 0.
- TURN: one bubble cycle, no RAM activity; then IDLE. This lets the requester update its address and request before the next arbitration.
- Latency: a request seen in IDLE at cycle 0 gives the grant at cycle 1. Earliest hit is cycle 1; next arbitration is cycle 3.
- Abort: if the owner's request deasserts in a grant state, the ram strobes fall the same cycle (combinational), there is no hit, and the next state is IDLE.
- ERROR: ramstate==ERROR in a grant state gives mem_err=1 that cycle, no hit, next state TURN.
- Timeout:
  - tcount clears on entering a grant state and increments each grant cycle without ACCESS/ERROR.
  - When tcount==TIMEOUT-1 and TIMEOUT!=0: mem_err=1, no hit, next state TURN.
- Precedence in a grant cycle: abort > ACCESS > ERROR > timeout.
- busy=1 in GNT_I, GNT_D and TURN.

Decomposition:
- cpu_types_pkg: add arb_state_t (IDLE, GNT_I, GNT_D, TURN); reuse the existing word_t and ramstate_t.
- No sub-module. Counter widths: dstreak uses $clog2(MAX_DSTREAK+1); tcount uses $clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Reset during GNT_D with ramWEN=1 -> ramWEN=0 and busy=0 immediately; after release, state is IDLE and all outputs are 0.
- iREN only, iaddr=0x40, RAM returns ACCESS on the 2nd grant cycle with ramload=0x8C220004 -> ihit pulses for 1 cycle at cycle 2 with iload=0x8C220004; busy drops at cycle 4.
- iREN and dREN both held continuously, fixed 1-cycle RAM, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; ihit never missing for more than 4 data hits.
- dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit pulses with dload=0.
- dREN dropped on the 2nd GNT_D cycle before ACCESS -> no dhit, no mem_err, ram strobes 0 that cycle, next state IDLE.
- ramstate stuck BUSY, TIMEOUT=8 -> mem_err pulses on the 8th grant cycle, no hit, then TURN then IDLE. Separately, ramstate=ERROR -> mem_err in the same cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, RAM handshake and memory-arbiter state types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2, TURN = 2'd3} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data with data priority,
// a fetch starvation limit, and timeout/error aborts.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  word_t       iaddr,
  output word_t       iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output word_t       dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic [1:0]  ramstate,
  output logic        busy,
  output logic        mem_err
);
  localparam int DW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  arb_state_t state_q, state_d;
  logic [DW-1:0] dstreak_q, dstreak_d;
  logic [TW-1:0] tcount_q, tcount_d;
  ramstate_t rs;
  logic dreq, gi, gd, owner, done, err, tmo;
  assign rs    = ramstate_t'(ramstate);
  assign dreq  = dREN | dWEN;
  assign gi    = state_q == GNT_I;
  assign gd    = state_q == GNT_D;
  assign owner = gi ? iREN : dreq;
  assign done  = (gi | gd) & owner & (rs == ACCESS);
  assign err   = (gi | gd) & owner & (rs == ERROR);
  assign tmo   = (gi | gd) & owner & (rs != ACCESS) & (rs != ERROR) & (TIMEOUT != 0) & (tcount_q == TLAST);
  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    tcount_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (dreq && !(iREN && dstreak_q == DMAX)) begin
          state_d   = GNT_D;
          dstreak_d = iREN ? dstreak_q + 1'b1 : '0;
        end else if (iREN) begin
          state_d   = GNT_I;
          dstreak_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        // a dropped request aborts straight to IDLE, ahead of any RAM response
        state_d  = !owner ? IDLE : (done | err | tmo) ? TURN : state_q;
        tcount_d = tcount_q + 1'b1;
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      tcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      tcount_q  <= tcount_d;
    end
  end
  assign ramREN   = gi ? iREN : gd ? (dREN & ~dWEN) : 1'b0;
  assign ramWEN   = gd & dWEN;
  assign ramaddr  = gi ? iaddr : gd ? daddr : '0;
  assign ramstore = gd ? dstore : '0;
  assign ihit     = gi & done;
  assign dhit     = gd & done;
  assign iload    = ihit ? ramload : '0;
  assign dload    = (dhit & ~dWEN) ? ramload : '0;
  assign mem_err  = err | tmo;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; hits are popped against
// expectations pushed when each request is issued.
module tb_mem_arbiter;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
  localparam logic [31:0] KEY = 32'h5A5A_0000;
  typedef struct {logic d; logic [31:0] load;} exp_t;
  logic CLK = 0, nRST = 0;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, man_load = 0;
  logic [1:0] man_state = RS_FREE;
  logic auto_ram = 0;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  logic ihit, dhit, ramREN, ramWEN, busy, mem_err;
  int vecs = 0, errs = 0;
  exp_t sb[$];
  logic [7:0] order[$];
  always #5 CLK = ~CLK;
  assign ramstate = auto_ram ? ((ramREN | ramWEN) ? RS_ACCESS : RS_FREE) : man_state;
  assign ramload  = auto_ram ? (ramaddr ^ KEY) : man_load;
  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .busy(busy), .mem_err(mem_err));
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && (ihit || dhit)) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++; $display("FAIL unexpected_hit: ihit=%b dhit=%b with empty scoreboard", ihit, dhit);
      end else begin
        e = sb.pop_front();
        if (dhit !== e.d || ihit === dhit || (dhit ? dload : iload) !== e.load) begin
          errs++;
          $display("FAIL hit_data: got ihit=%b dhit=%b load=%h, expected %s hit load=%h",
                   ihit, dhit, dhit ? dload : iload, e.d ? "data" : "fetch", e.load);
        end
      end
      order.push_back(dhit ? "D" : "I");
    end
  end
  task automatic step;
    @(posedge CLK); #1;
  endtask
  task automatic test_reset;
    repeat (2) step();
    @(negedge CLK);
    vecs++; if ({busy, ramREN, ramWEN, ihit, dhit, mem_err} !== 6'b0 || ramaddr !== 0) begin
      errs++; $display("FAIL reset_outputs: busy=%b ren=%b wen=%b addr=%h, expected all 0", busy, ramREN, ramWEN, ramaddr); end
    step(); nRST = 1;
    step(); dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h55; man_state = RS_BUSY;
    step();
    @(negedge CLK);
    vecs++; if (ramWEN !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL pre_reset_write: wen=%b busy=%b, expected 1 1", ramWEN, busy); end
    #1 nRST = 0;
    #1;
    vecs++; if (ramWEN !== 1'b0 || busy !== 1'b0 || ramaddr !== 0) begin
      errs++; $display("FAIL async_reset: wen=%b busy=%b addr=%h, expected 0 0 0", ramWEN, busy, ramaddr); end
    dREN = 0; dWEN = 0; man_state = RS_FREE;
    step(); step(); nRST = 1;
    step();
    @(negedge CLK);
    vecs++; if ({busy, ramREN, ramWEN, ihit, dhit, mem_err} !== 6'b0 || ramstore !== 0) begin
      errs++; $display("FAIL post_reset_idle: busy=%b ren=%b wen=%b, expected 0", busy, ramREN, ramWEN); end
    step();
  endtask
  task automatic test_ifetch;
    iREN = 1; iaddr = 32'h40; man_state = RS_FREE;
    sb.push_back('{d: 1'b0, load: 32'h8C22_0004});
    @(negedge CLK);
    vecs++; if (busy !== 1'b0 || ramREN !== 1'b0) begin
      errs++; $display("FAIL if_cycle0: busy=%b ren=%b, expected 0 0", busy, ramREN); end
    step(); man_state = RS_BUSY;
    @(negedge CLK);
    vecs++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
      errs++; $display("FAIL if_cycle1: ren=%b addr=%h ihit=%b, expected 1 40 0", ramREN, ramaddr, ihit); end
    step(); man_state = RS_ACCESS; man_load = 32'h8C22_0004;
    @(negedge CLK);
    vecs++; if (ihit !== 1'b1 || iload !== 32'h8C22_0004) begin
      errs++; $display("FAIL if_cycle2: ihit=%b iload=%h, expected 1 8c220004", ihit, iload); end
    step(); iREN = 0; man_state = RS_FREE;
    @(negedge CLK);
    vecs++; if (ihit !== 1'b0 || iload !== 0 || busy !== 1'b1 || ramREN !== 1'b0) begin
      errs++; $display("FAIL if_turn: ihit=%b iload=%h busy=%b ren=%b, expected 0 0 1 0", ihit, iload, busy, ramREN); end
    step();
    @(negedge CLK);
    vecs++; if (busy !== 1'b0) begin
      errs++; $display("FAIL if_cycle4_busy: busy=%b, expected 0", busy); end
    step();
  endtask
  task automatic test_write;
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    sb.push_back('{d: 1'b1, load: 32'h0});
    step(); man_state = RS_ACCESS; man_load = 32'h1234_5678;
    @(negedge CLK);
    vecs++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h100) begin
      errs++; $display("FAIL wr_strobes: wen=%b ren=%b store=%h addr=%h, expected 1 0 deadbeef 100", ramWEN, ramREN, ramstore, ramaddr); end
    vecs++; if (dhit !== 1'b1 || dload !== 0) begin
      errs++; $display("FAIL wr_hit: dhit=%b dload=%h, expected 1 0", dhit, dload); end
    step(); dREN = 0; dWEN = 0; man_state = RS_FREE;
    @(negedge CLK);
    vecs++; if (dhit !== 1'b0 || ramWEN !== 1'b0) begin
      errs++; $display("FAIL wr_turn: dhit=%b wen=%b, expected 0 0", dhit, ramWEN); end
    step(); step();
  endtask
  task automatic test_abort;
    dREN = 1; daddr = 32'h200; man_state = RS_BUSY;
    step();
    @(negedge CLK);
    vecs++; if (ramREN !== 1'b1) begin
      errs++; $display("FAIL ab_grant: ren=%b, expected 1", ramREN); end
    step(); dREN = 0; man_state = RS_ACCESS;
    @(negedge CLK);
    vecs++; if (dhit !== 1'b0 || mem_err !== 1'b0 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      errs++; $display("FAIL ab_drop: dhit=%b err=%b ren=%b wen=%b, expected 0 0 0 0", dhit, mem_err, ramREN, ramWEN); end
    step(); man_state = RS_FREE;
    @(negedge CLK);
    vecs++; if (busy !== 1'b0) begin
      errs++; $display("FAIL ab_to_idle: busy=%b, expected 0 (IDLE, not TURN)", busy); end
    step();
  endtask
  task automatic test_timeout;
    iREN = 1; iaddr = 32'h80; man_state = RS_BUSY;
    for (int k = 1; k <= 8; k++) begin
      step();
      @(negedge CLK);
      vecs++; if (mem_err !== (k == 8) || ihit !== 1'b0) begin
        errs++; $display("FAIL tmo_cycle%0d: mem_err=%b ihit=%b, expected %b 0", k, mem_err, ihit, k == 8); end
    end
    step(); iREN = 0; man_state = RS_FREE;
    @(negedge CLK);
    vecs++; if (busy !== 1'b1 || mem_err !== 1'b0 || ramREN !== 1'b0) begin
      errs++; $display("FAIL tmo_turn: busy=%b err=%b ren=%b, expected 1 0 0", busy, mem_err, ramREN); end
    step();
    @(negedge CLK);
    vecs++; if (busy !== 1'b0) begin
      errs++; $display("FAIL tmo_idle: busy=%b, expected 0", busy); end
    step();
  endtask
  task automatic test_error;
    dREN = 1; daddr = 32'h400; man_state = RS_BUSY;
    step(); man_state = RS_ERROR;
    @(negedge CLK);
    vecs++; if (mem_err !== 1'b1 || dhit !== 1'b0) begin
      errs++; $display("FAIL err_same_cycle: mem_err=%b dhit=%b, expected 1 0", mem_err, dhit); end
    step(); dREN = 0; man_state = RS_FREE;
    @(negedge CLK);
    vecs++; if (mem_err !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL err_turn: mem_err=%b busy=%b, expected 0 1", mem_err, busy); end
    step(); step();
  endtask
  task automatic test_back_to_back;
    logic [7:0] exp_order[$];
    int streak = 0, run = 0, max_run = 0, cyc = 0;
    for (int n = 0; n < 10; n++) begin
      if (streak == 4) begin exp_order.push_back("I"); streak = 0; sb.push_back('{d: 1'b0, load: 32'h1000 ^ KEY}); end
      else begin exp_order.push_back("D"); streak++; sb.push_back('{d: 1'b1, load: 32'h2000 ^ KEY}); end
    end
    order.delete();
    auto_ram = 1; iaddr = 32'h1000; daddr = 32'h2000; dWEN = 0; iREN = 1; dREN = 1;
    while (order.size() < 10 && cyc < 200) begin @(posedge CLK); cyc++; end
    #1 iREN = 0; dREN = 0;
    vecs++; if (order.size() < 10) begin
      errs++; $display("FAIL b2b_timeout: got %0d hits in %0d cycles, expected 10", order.size(), cyc); end
    for (int n = 0; n < 10 && n < order.size(); n++) begin
      vecs++; if (order[n] !== exp_order[n]) begin
        errs++; $display("FAIL b2b_order[%0d]: got %s expected %s", n, order[n], exp_order[n]); end
      run = (order[n] == "D") ? run + 1 : 0;
      max_run = (run > max_run) ? run : max_run;
    end
    vecs++; if (max_run > 4) begin
      errs++; $display("FAIL b2b_starvation: %0d consecutive data hits, expected at most 4", max_run); end
    repeat (3) step();
    auto_ram = 0;
    vecs++; if (sb.size() != 0 || busy !== 1'b0) begin
      errs++; $display("FAIL b2b_drain: %0d pending busy=%b, expected 0 0", sb.size(), busy); end
  endtask
  initial begin
    test_reset();
    test_ifetch();
    test_write();
    test_abort();
    test_timeout();
    test_error();
    test_back_to_back();
    vecs++; if (sb.size() != 0) begin
      errs++; $display("FAIL scoreboard_empty: %0d expected hits never seen, expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
